// File: rtl/rtc_day_bcd_loader.sv
// rtc_day_bcd_loader: validates a packed BCD day byte, converts it to a 0..30 binary count and commits it; also does up/down day editing.
// Optional out-of-range clamping on loads is enabled by defining RTC_DAY_CLAMP_EN.
module rtc_day_bcd_loader #(
    parameter int N        = 5,
    parameter int EDIT_SEL = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   data_in,
    input  logic         load_stb,
    input  logic [3:0]   en_count,
    input  logic         enUP,
    input  logic         enDOWN,
    output logic         busy,
    output logic         load_ack,
    output logic         load_err,
    output logic [N-1:0] day_bin
);
    typedef enum logic [1:0] {IDLE, CHECK, COMMIT, REJECT} state_t;

    state_t       state_q, state_d;
    logic [7:0]   shadow_q, shadow_d;
    logic [N-1:0] day_q, day_d;
    logic         err_q, err_d;
    logic [3:0]   tens, units;
    logic         digits_ok, range_ok, accept;
    logic [N-1:0] conv, commit_val;

    assign tens      = shadow_q[7:4];
    assign units     = shadow_q[3:0];
    assign digits_ok = (tens <= 4'd3) && (units <= 4'd9);
    // With legal digits the BCD byte orders the same as its decimal value
    assign range_ok  = (shadow_q != 8'h00) && (shadow_q <= 8'h31);
    assign conv      = N'({tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, units}) - N'(1);

`ifdef RTC_DAY_CLAMP_EN
    assign accept     = digits_ok;
    assign commit_val = (shadow_q == 8'h00) ? '0 : (range_ok ? conv : N'(30));
`else
    assign accept     = digits_ok && range_ok;
    assign commit_val = conv;
`endif

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        day_d    = day_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (load_stb) begin
                    shadow_d = data_in;
                    state_d  = CHECK;
                end else if (en_count == 4'(EDIT_SEL)) begin
                    if (enUP)
                        day_d = (day_q >= N'(30)) ? '0 : day_q + N'(1);
                    else if (enDOWN)
                        day_d = (day_q == '0) ? N'(30) : day_q - N'(1);
                end
            end
            CHECK:   state_d = accept ? COMMIT : REJECT;
            COMMIT: begin
                day_d   = commit_val;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shadow_q <= 8'h00;
            day_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            day_q    <= day_d;
            err_q    <= err_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign load_ack = (state_q == COMMIT) || (state_q == REJECT);
    assign load_err = err_q;
    assign day_bin  = day_q;
endmodule

// File: tb/tb_rtc_day_bcd_loader.sv
// tb_rtc_day_bcd_loader: scoreboard bench; loads push expected {day, err} and a monitor checks them after each load_ack.
module tb_rtc_day_bcd_loader;
    logic       clk = 0, reset = 0, load_stb = 0, enUP = 0, enDOWN = 0;
    logic [7:0] data_in = 0;
    logic [3:0] en_count = 0;
    logic       busy, load_ack, load_err;
    logic [4:0] day_bin;

    int checks = 0, errors = 0;
    int m_day = 0, m_err = 0;
    int exp_q[$];

    rtc_day_bcd_loader dut (
        .clk(clk), .reset(reset), .data_in(data_in), .load_stb(load_stb),
        .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN),
        .busy(busy), .load_ack(load_ack), .load_err(load_err), .day_bin(day_bin)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decimal value of the digits, day = value-1 when 1..31
    task automatic model_load(input logic [7:0] v);
        int t, u, val;
        bit legal;
        t = int'(v[7:4]);
        u = int'(v[3:0]);
        val = t * 10 + u;
        legal = (t <= 3) && (u <= 9);
        if (legal && val >= 1 && val <= 31) begin
            m_day = val - 1; m_err = 0;
`ifdef RTC_DAY_CLAMP_EN
        end else if (legal) begin
            m_day = (val == 0) ? 0 : 30; m_err = 0;
`endif
        end else begin
            m_err = 1;
        end
        exp_q.push_back(m_day * 2 + m_err);
    endtask

    task automatic do_load(input logic [7:0] v, input bit with_up, input bit second_stb);
        @(posedge clk) #1;
        data_in = v; load_stb = 1; en_count = 4'd6; enUP = with_up;
        model_load(v);
        @(posedge clk) #1;
        enUP = 0;
        load_stb = second_stb;
        data_in = 8'h05;
        chk("busy_T1", int'(busy), 1);
        @(posedge clk) #1;
        load_stb = 0;
        chk("busy_T2", int'(busy), 1);
        chk("ack_T2", int'(load_ack), 1);
        @(posedge clk) #1;
        chk("busy_T3", int'(busy), 0);
    endtask

    task automatic do_edit(input bit up, input bit dn, input logic [3:0] sel);
        @(posedge clk) #1;
        enUP = up; enDOWN = dn; en_count = sel;
        @(posedge clk) #1;
        enUP = 0; enDOWN = 0;
        if (sel == 4'd6) begin
            if (up) m_day = (m_day >= 30) ? 0 : m_day + 1;
            else if (dn) m_day = (m_day == 0) ? 30 : m_day - 1;
        end
        chk("edit_day", int'(day_bin), m_day);
    endtask

    initial begin : monitor
        int e;
        bit pending = 0;
        forever begin
            @(negedge clk);
            if (pending) begin
                chk("load_day", int'(day_bin), e / 2);
                chk("load_err", int'(load_err), e % 2);
                pending = 0;
            end
            if (load_ack) begin
                if (exp_q.size() == 0) chk("spurious_ack", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    pending = 1;
                end
            end
        end
    end

    initial begin : stim
        logic [7:0] v;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ack", int'(load_ack), 0);
        chk("rst_err", int'(load_err), 0);
        chk("rst_day", int'(day_bin), 0);
        reset = 1;
        do_load(8'h15, 0, 0);
        do_load(8'h01, 0, 0);
        do_load(8'h31, 0, 0);
        do_load(8'h10, 0, 0);
        do_load(8'h1A, 0, 0);
        do_load(8'h40, 0, 0);
        do_load(8'h20, 0, 0);
        do_load(8'h31, 0, 0);
        do_edit(1, 0, 4'd6);
        do_edit(0, 1, 4'd6);
        do_edit(1, 1, 4'd6);
        do_edit(1, 0, 4'd5);
        do_edit(0, 1, 4'd5);
        do_load(8'h07, 1, 0);
        do_load(8'h12, 0, 1);
        do_load(8'h35, 0, 0);
        do_load(8'h00, 0, 0);
        do_load(8'h28, 0, 0);
        // Reset during CHECK aborts the load with no ack
        @(posedge clk) #1;
        data_in = 8'h25; load_stb = 1;
        @(posedge clk) #1;
        load_stb = 0;
        reset = 0;
        m_day = 0; m_err = 0;
        #2;
        chk("abort_busy", int'(busy), 0);
        chk("abort_day", int'(day_bin), 0);
        chk("abort_err", int'(load_err), 0);
        @(posedge clk) #1;
        reset = 1;
        chk("abort_ack", int'(load_ack), 0);
        @(posedge clk) #1;
        chk("abort_ack2", int'(load_ack), 0);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) == 0)
                do_edit(1'($urandom), 1'($urandom), $urandom_range(0, 1) == 0 ? 4'd6 : 4'($urandom));
            else begin
                v = ($urandom_range(0, 1) == 0) ? 8'($urandom) : {4'($urandom_range(0, 3)), 4'($urandom_range(0, 9))};
                do_load(v, 1'($urandom), 1'($urandom));
            end
        end
        repeat (3) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
